// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low digit patterns used by both the
// display drivers (encode) and the scan decoder (decode).
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    // Active-low patterns, bit order g,f,e,d,c,b,a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Multiply a BCD digit by ten using shifts only; result fits 7 bits (max 90)
    function automatic logic [6:0] times_ten(input logic [3:0] d);
        logic [6:0] d_ext;
        d_ext = {3'b000, d};
        return (d_ext << 3) + (d_ext << 1);
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational reverse lookup: active-low 7-bit segment pattern to BCD value.
// Anything not in the digit table and not blank is reported as illegal.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       is_digit,
    output logic       is_blank,
    output logic       is_illegal
);

    // Table lookup against the shared pattern constants
    always_comb begin
        value      = DIGIT_BLANK;
        is_digit   = 1'b0;
        is_blank   = 1'b0;
        is_illegal = 1'b0;
        case (pattern)
            SEG_0:     begin value = 4'd0; is_digit = 1'b1; end
            SEG_1:     begin value = 4'd1; is_digit = 1'b1; end
            SEG_2:     begin value = 4'd2; is_digit = 1'b1; end
            SEG_3:     begin value = 4'd3; is_digit = 1'b1; end
            SEG_4:     begin value = 4'd4; is_digit = 1'b1; end
            SEG_5:     begin value = 4'd5; is_digit = 1'b1; end
            SEG_6:     begin value = 4'd6; is_digit = 1'b1; end
            SEG_7:     begin value = 4'd7; is_digit = 1'b1; end
            SEG_8:     begin value = 4'd8; is_digit = 1'b1; end
            SEG_9:     begin value = 4'd9; is_digit = 1'b1; end
            SEG_BLANK: begin is_blank = 1'b1; end
            default:   begin is_illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive-side 7-segment monitor: samples the active-low anode/segment bus,
// waits for STABLE_CYCLES identical samples, then commits the decoded digit.
// Digits 1:0 are also combined into a binary tens/ones value.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  AN,
    input  logic [7:0]  SEG,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [3:0]  digit_err,
    output logic        upd,
    output logic [1:0]  upd_idx,
    output logic [6:0]  count_bin,
    output logic        count_ok,
    output logic        multi_an_err
);

    localparam logic [7:0] STABLE_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

    logic [11:0] sample_r;
    logic [7:0]  stable_cnt_r;
    logic        committed_r;

    logic [15:0] digits_r;
    logic [3:0]  digit_valid_r;
    logic [3:0]  digit_err_r;
    logic        upd_r;
    logic [1:0]  upd_idx_r;
    logic [6:0]  count_bin_r;
    logic        count_ok_r;
    logic        multi_an_err_r;
    logic        count_upd_r;

    logic [11:0] bus_s;
    logic        same_s;
    logic        commit_s;
    logic [3:0]  an_low_s;
    logic        one_hot_s;
    logic        multi_s;
    logic [1:0]  idx_s;
    logic [3:0]  dec_value_s;
    logic        dec_digit_s;
    logic        dec_blank_s;
    logic        dec_illegal_s;
    logic        pair_ok_s;
    logic [6:0]  pair_bin_s;

    assign bus_s    = {AN, SEG};
    assign same_s   = (bus_s == sample_r);
    // Fires once, on the edge that brings the counter to STABLE_CYCLES
    assign commit_s = same_s && (stable_cnt_r == STABLE_LAST) && !committed_r;

    // DP (sample bit 7) takes part in stability but not in decoding
    seg7_pattern_decode u_decode (
        .pattern    (sample_r[6:0]),
        .value      (dec_value_s),
        .is_digit   (dec_digit_s),
        .is_blank   (dec_blank_s),
        .is_illegal (dec_illegal_s)
    );

    // Classify the held anode sample: single digit, idle, or several selected
    always_comb begin
        an_low_s  = ~sample_r[11:8];
        one_hot_s = (an_low_s != 4'b0000) && ((an_low_s & (an_low_s - 4'd1)) == 4'b0000);
        multi_s   = (an_low_s != 4'b0000) && !one_hot_s;
        case (an_low_s)
            4'b0001: idx_s = 2'd0;
            4'b0010: idx_s = 2'd1;
            4'b0100: idx_s = 2'd2;
            4'b1000: idx_s = 2'd3;
            default: idx_s = 2'd0;
        endcase
    end

    // Tens/ones combination of digits 1:0; blank or invalid yields not-ok
    always_comb begin
        pair_ok_s = digit_valid_r[1] && digit_valid_r[0] &&
                    (digits_r[7:4] <= 4'd9) && (digits_r[3:0] <= 4'd9);
        if (pair_ok_s) begin
            pair_bin_s = times_ten(digits_r[7:4]) + {3'b000, digits_r[3:0]};
        end else begin
            pair_bin_s = 7'd0;
        end
    end

    // Input sample register, stability counter and one-commit-per-interval flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_r     <= 12'hFFF;
            stable_cnt_r <= 8'd0;
            committed_r  <= 1'b0;
        end else begin
            sample_r <= bus_s;
            if (!same_s) begin
                stable_cnt_r <= 8'd1;
                committed_r  <= 1'b0;
            end else begin
                if (stable_cnt_r < STABLE_MAX) begin
                    stable_cnt_r <= stable_cnt_r + 8'd1;
                end else begin
                    stable_cnt_r <= stable_cnt_r;
                end
                if (commit_s) begin
                    committed_r <= 1'b1;
                end else begin
                    committed_r <= committed_r;
                end
            end
        end
    end

    // Commit the decoded pattern into the selected digit and pulse upd
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_r       <= 16'hFFFF;
            digit_valid_r  <= 4'b0000;
            digit_err_r    <= 4'b0000;
            upd_r          <= 1'b0;
            upd_idx_r      <= 2'd0;
            multi_an_err_r <= 1'b0;
            count_upd_r    <= 1'b0;
        end else begin
            upd_r       <= commit_s && one_hot_s;
            count_upd_r <= commit_s && one_hot_s && !idx_s[1];
            if (commit_s && one_hot_s) begin
                upd_idx_r                      <= idx_s;
                digits_r[{idx_s, 2'b00} +: 4]  <= dec_digit_s ? dec_value_s : DIGIT_BLANK;
                digit_valid_r[idx_s]           <= dec_digit_s || dec_blank_s;
                digit_err_r[idx_s]             <= dec_illegal_s;
            end else begin
                upd_idx_r <= upd_idx_r;
            end
            if (commit_s && multi_s) begin
                multi_an_err_r <= 1'b1;
            end else begin
                multi_an_err_r <= multi_an_err_r;
            end
        end
    end

    // Refresh the binary pair value the cycle after digit 0 or 1 changes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_bin_r <= 7'd0;
            count_ok_r  <= 1'b0;
        end else if (count_upd_r) begin
            count_bin_r <= pair_bin_s;
            count_ok_r  <= pair_ok_s;
        end else begin
            count_bin_r <= count_bin_r;
            count_ok_r  <= count_ok_r;
        end
    end

    assign digits       = digits_r;
    assign digit_valid  = digit_valid_r;
    assign digit_err    = digit_err_r;
    assign upd          = upd_r;
    assign upd_idx      = upd_idx_r;
    assign count_bin    = count_bin_r;
    assign count_ok     = count_ok_r;
    assign multi_an_err = multi_an_err_r;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: stimulus pushes the expected commit
// (cycle, digit, flags, pair value); a monitor pops on every upd pulse.
module tb_seg7_scan_decoder;

    localparam int STB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  AN;
    logic [7:0]  SEG;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  digit_err;
    logic        upd;
    logic [1:0]  upd_idx;
    logic [6:0]  count_bin;
    logic        count_ok;
    logic        multi_an_err;

    seg7_scan_decoder #(.STABLE_CYCLES(STB)) dut (
        .clk          (clk),
        .rst          (rst),
        .AN           (AN),
        .SEG          (SEG),
        .digits       (digits),
        .digit_valid  (digit_valid),
        .digit_err    (digit_err),
        .upd          (upd),
        .upd_idx      (upd_idx),
        .count_bin    (count_bin),
        .count_ok     (count_ok),
        .multi_an_err (multi_an_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] idx;
        logic [3:0] val;
        logic       v;
        logic       e;
        bit         chk;
        logic       ok;
        logic [6:0] bin;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one bus value, optionally queue the commit it must produce, then hold
    task automatic apply(input logic [3:0] an, input logic [7:0] seg, input int hold,
                         input bit push, input logic [1:0] idx, input logic [3:0] val,
                         input logic v, input logic e, input bit chk,
                         input logic ok, input logic [6:0] bin);
        exp_t x;
        @(negedge clk);
        AN  = an;
        SEG = seg;
        x.cyc = cyc + STB;
        x.idx = idx; x.val = val; x.v = v; x.e = e;
        x.chk = chk; x.ok = ok; x.bin = bin;
        if (push) q.push_back(x);
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits"}, digits, 16'hFFFF);
        check({tag, "_valid"}, digit_valid, 4'b0000);
        check({tag, "_err"}, digit_err, 4'b0000);
        check({tag, "_upd"}, upd, 1'b0);
        check({tag, "_upd_idx"}, upd_idx, 2'd0);
        check({tag, "_count_bin"}, count_bin, 7'd0);
        check({tag, "_count_ok"}, count_ok, 1'b0);
        check({tag, "_multi"}, multi_an_err, 1'b0);
    endtask

    // Monitor: pop and compare on every upd; pair value checked one cycle later
    bit   pend = 1'b0;
    exp_t pe;
    exp_t me;
    initial begin
        forever begin
            @(negedge clk);
            if (pend) begin
                check("count_ok", count_ok, pe.ok);
                check("count_bin", count_bin, pe.bin);
                pend = 1'b0;
            end
            if (upd === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL upd_unexpected: upd=1 idx=%0d cycle=%0d with nothing queued",
                             upd_idx, cyc);
                end else begin
                    me = q.pop_front();
                    check("upd_cycle", cyc, me.cyc);
                    check("upd_idx", upd_idx, me.idx);
                    check("digit_val", digits[4*me.idx +: 4], me.val);
                    check("digit_valid", digit_valid[me.idx], me.v);
                    check("digit_err", digit_err[me.idx], me.e);
                    if (me.chk) begin
                        pe   = me;
                        pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        AN  = 4'hF;
        SEG = 8'hFF;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Single digit, then scan two digits, then a pair for count_bin
        apply(4'hE, 8'hC0, 10, 1'b1, 2'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0);
        apply(4'h7, 8'h90, 8,  1'b1, 2'd3, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
        apply(4'hE, 8'hF9, 8,  1'b1, 2'd0, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0);
        apply(4'hD, 8'hA4, 8,  1'b1, 2'd1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 7'd21);
        apply(4'hE, 8'h92, 8,  1'b1, 2'd0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 7'd25);

        // Too-short dwells must be ignored
        for (int i = 0; i < 10; i++) begin
            apply(4'hE, (i % 2 == 0) ? 8'hC0 : 8'hF9, 2, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        end
        apply(4'hF, 8'hFF, 8, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        check("glitch_digits", digits, 16'h9F25);
        check("glitch_valid", digit_valid, 4'b1011);

        // Two anodes low: sticky error, no capture
        check("multi_before", multi_an_err, 1'b0);
        apply(4'hC, 8'hC0, 10, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        check("multi_after", multi_an_err, 1'b1);
        check("multi_digits", digits, 16'h9F25);

        // Repeated identical commit still pulses upd
        apply(4'hE, 8'h92, 8, 1'b1, 2'd0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 7'd25);
        apply(4'hF, 8'hFF, 8, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        apply(4'hE, 8'h92, 8, 1'b1, 2'd0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 7'd25);

        // Blank is valid but not numeric; illegal pattern sets err
        apply(4'hE, 8'hFF, 8, 1'b1, 2'd0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0);
        apply(4'hE, 8'hFE, 8, 1'b1, 2'd0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0);
        check("illegal_err_vec", digit_err, 4'b0001);
        check("illegal_valid_vec", digit_valid, 4'b1010);

        // DP low is ignored by the decode
        apply(4'hD, 8'h24, 8, 1'b1, 2'd1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0);
        check("multi_still_set", multi_an_err, 1'b1);

        // Asynchronous reset on the cycle before a commit
        @(negedge clk);
        AN  = 4'hE;
        SEG = 8'hC0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(negedge clk);
        apply(4'hE, 8'hC0, 1, 1'b1, 2'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        check("queue_drained", q.size(), 0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
